// File: rtl/counter_ctrl_pkg.sv
// Types and helpers shared by the counter controller.
// State codes come from the reusable defs include.
package counter_ctrl_pkg;

  `include "counter_ctrl_defs.vh"

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = S_IDLE,
    ST_LOAD = S_LOAD,
    ST_RUN  = S_RUN,
    ST_HOLD = S_HOLD,
    ST_DONE = S_DONE
  } state_e;

  typedef enum logic [1:0] {
    CMD_NONE,
    CMD_HOLD,
    CMD_START,
    CMD_STOP
  } cmd_e;

  // stop beats start beats hold
  function automatic cmd_e cmd_decode(
    input logic stop,
    input logic start,
    input logic hold
  );
    cmd_e c;
    c = CMD_NONE;
    priority case (1'b1)
      stop:    c = CMD_STOP;
      start:   c = CMD_START;
      hold:    c = CMD_HOLD;
      default: c = CMD_NONE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/counter_ctrl_if.sv
// Control strobes, configuration and status of the counter controller.
// master drives commands; slave is the controller.
interface counter_ctrl_if #(
  parameter int WIDTH     = 8,
  parameter int PRE_WIDTH = 4
);
  import counter_ctrl_pkg::*;

  logic                 start;
  logic                 stop;
  logic                 hold;
  logic                 dir;
  logic                 auto_reload;
  logic [WIDTH-1:0]     load_val;
  logic [PRE_WIDTH-1:0] prescale;
  logic [WIDTH-1:0]     count;
  logic                 tc_pulse;
  logic                 busy;
  logic                 done;
  logic [STATE_W-1:0]   state;

  modport master (
    output start, stop, hold, dir, auto_reload,
    output load_val, prescale,
    input  count, tc_pulse, busy, done, state
  );

  modport slave (
    input  start, stop, hold, dir, auto_reload,
    input  load_val, prescale,
    output count, tc_pulse, busy, done, state
  );

endinterface

// File: rtl/counter_ctrl_defs.vh
// Shared state encoding for counter controllers and their benches.
// Included inside a package or module scope, so it only holds localparams.
localparam int STATE_W = 3;
localparam logic [STATE_W-1:0] S_IDLE = 3'd0;
localparam logic [STATE_W-1:0] S_LOAD = 3'd1;
localparam logic [STATE_W-1:0] S_RUN  = 3'd2;
localparam logic [STATE_W-1:0] S_HOLD = 3'd3;
localparam logic [STATE_W-1:0] S_DONE = 3'd4;

// File: rtl/counter_prescaler.sv
// Tick divider: one tick every div+1 enabled cycles.
// clr wins over en; a disabled prescaler keeps its phase.
module counter_prescaler #(
  parameter int PRE_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  input  logic [PRE_WIDTH-1:0] div,
  output logic                 tick
);

  logic [PRE_WIDTH-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == div);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/counter_ctrl.sv
// Sequencer for a programmable up/down modulo counter.
// Config is shadowed on entry to LOAD; all outputs come from flops.
module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int PRE_WIDTH = 4
) (
  input logic           clk,
  input logic           rst,
  counter_ctrl_if.slave bus
);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     count_q, count_d;
  logic [WIDTH-1:0]     lv_q, lv_d;
  logic [PRE_WIDTH-1:0] ps_q, ps_d;
  logic                 dir_q, dir_d;
  logic                 ar_q, ar_d;
  logic                 tc_q, tc_d;

  logic [WIDTH-1:0]     start_val;
  logic                 at_term;
  logic                 pre_clr;
  logic                 pre_en;
  logic                 tick;
  cmd_e                 cmd;

  assign cmd       = cmd_decode(bus.stop, bus.start, bus.hold);
  assign start_val = dir_q ? '0 : lv_q;
  assign at_term   = dir_q ? (count_q == lv_q) : (count_q == '0);
  assign pre_clr   = (state_q == ST_LOAD);
  // prescaler only advances on a RUN cycle with no command pending
  assign pre_en    = (state_q == ST_RUN) && (cmd == CMD_NONE);

  counter_prescaler #(
    .PRE_WIDTH(PRE_WIDTH)
  ) u_pre (
    .clk  (clk),
    .rst  (rst),
    .clr  (pre_clr),
    .en   (pre_en),
    .div  (ps_q),
    .tick (tick)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    tc_d    = 1'b0;
    dir_d   = dir_q;
    ar_d    = ar_q;
    lv_d    = lv_q;
    ps_d    = ps_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd == CMD_START) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (cmd == CMD_STOP) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RUN;
          count_d = start_val;
        end
      end
      ST_RUN: begin
        case (cmd)
          CMD_STOP:  state_d = ST_IDLE;
          CMD_START: state_d = ST_LOAD;
          CMD_HOLD:  state_d = ST_HOLD;
          default: begin
            if (tick) begin
              if (at_term) begin
                tc_d = 1'b1;
                if (ar_q) count_d = start_val;
                else      state_d = ST_DONE;
              end else if (dir_q) begin
                count_d = count_q + 1'b1;
              end else begin
                count_d = count_q - 1'b1;
              end
            end
          end
        endcase
      end
      ST_HOLD: begin
        case (cmd)
          CMD_STOP:  state_d = ST_IDLE;
          CMD_START: state_d = ST_LOAD;
          CMD_HOLD:  state_d = ST_HOLD;
          default:   state_d = ST_RUN;
        endcase
      end
      ST_DONE: begin
        case (cmd)
          CMD_STOP:  state_d = ST_IDLE;
          CMD_START: state_d = ST_LOAD;
          default:   state_d = ST_DONE;
        endcase
      end
      default: state_d = ST_IDLE;
    endcase
    // every path into LOAD takes a fresh config snapshot
    if (state_d == ST_LOAD) begin
      dir_d = bus.dir;
      ar_d  = bus.auto_reload;
      lv_d  = bus.load_val;
      ps_d  = bus.prescale;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      tc_q    <= 1'b0;
      dir_q   <= 1'b0;
      ar_q    <= 1'b0;
      lv_q    <= '0;
      ps_q    <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tc_q    <= tc_d;
      dir_q   <= dir_d;
      ar_q    <= ar_d;
      lv_q    <= lv_d;
      ps_q    <= ps_d;
    end
  end

  assign bus.count    = count_q;
  assign bus.tc_pulse = tc_q;
  assign bus.state    = state_q;
  assign bus.busy     = (state_q == ST_LOAD) ||
                        (state_q == ST_RUN)  ||
                        (state_q == ST_HOLD);
  assign bus.done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_counter_ctrl.sv
// Bench for counter_ctrl: directed scenarios plus random commands,
// scored against a cycle-count model of the counting rules.
module tb_counter_ctrl;

  localparam int IDLE = 0;
  localparam int LOAD = 1;
  localparam int RUN  = 2;
  localparam int HOLD = 3;
  localparam int DONE = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  counter_ctrl_if #(.WIDTH(8), .PRE_WIDTH(4)) bus ();

  counter_ctrl #(
    .WIDTH(8),
    .PRE_WIDTH(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int cnt;
    int st;
    int tc;
    int busy;
    int done;
  } exp_t;

  exp_t sbq[$];
  int n_chk = 0;
  int n_err = 0;

  int m_mode, m_cnt, m_cyc, m_dir, m_ar, m_lv, m_ps, m_tc;

  task automatic chk(string nm, int act, int want);
    n_chk++;
    if (act != want) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d at %0t", nm, act, want, $time);
    end
  endtask

  // count after m_cyc un-held RUN cycles since LOAD
  function automatic int cur_count();
    int n, idx;
    n = m_cyc / (m_ps + 1);
    idx = (m_ar == 0 && n > m_lv) ? m_lv : n % (m_lv + 1);
    return (m_dir != 0) ? idx : m_lv - idx;
  endfunction

  function automatic void model_reset();
    m_mode = IDLE; m_cnt = 0; m_cyc = 0; m_tc = 0;
    m_dir = 0; m_ar = 0; m_lv = 0; m_ps = 0;
  endfunction

  function automatic void capture();
    m_mode = LOAD;
    m_dir  = int'(bus.dir);
    m_ar   = int'(bus.auto_reload);
    m_lv   = int'(bus.load_val);
    m_ps   = int'(bus.prescale);
  endfunction

  function automatic void model_step();
    m_tc = 0;
    if (!rst) begin
      model_reset();
      return;
    end
    case (m_mode)
      IDLE: if (!bus.stop && bus.start) capture();
      LOAD: begin
        if (bus.stop) m_mode = IDLE;
        else begin
          m_mode = RUN;
          m_cyc = 0;
          m_cnt = cur_count();
        end
      end
      RUN: begin
        if (bus.stop) m_mode = IDLE;
        else if (bus.start) capture();
        else if (bus.hold) m_mode = HOLD;
        else begin
          m_cyc++;
          if (m_cyc % (m_ps + 1) == 0 &&
              (m_cyc / (m_ps + 1)) % (m_lv + 1) == 0) begin
            m_tc = 1;
            if (m_ar == 0) m_mode = DONE;
          end
          m_cnt = cur_count();
        end
      end
      HOLD: begin
        if (bus.stop) m_mode = IDLE;
        else if (bus.start) capture();
        else if (!bus.hold) m_mode = RUN;
      end
      DONE: begin
        if (bus.stop) m_mode = IDLE;
        else if (bus.start) capture();
      end
      default: m_mode = IDLE;
    endcase
  endfunction

  task automatic tick_cycle();
    exp_t e;
    @(posedge clk);
    model_step();
    e.cnt  = m_cnt;
    e.st   = m_mode;
    e.tc   = m_tc;
    e.busy = (m_mode >= LOAD && m_mode <= HOLD) ? 1 : 0;
    e.done = (m_mode == DONE) ? 1 : 0;
    sbq.push_back(e);
    #1;
  endtask

  task automatic set_cfg(input int d, input int ar, input int lv, input int ps);
    bus.dir         = 1'(d);
    bus.auto_reload = 1'(ar);
    bus.load_val    = 8'(lv);
    bus.prescale    = 4'(ps);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick_cycle();
    bus.start = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("sb_count", int'(bus.count), e.cnt);
        chk("sb_state", int'(bus.state), e.st);
        chk("sb_tc", int'(bus.tc_pulse), e.tc);
        chk("sb_busy", int'(bus.busy), e.busy);
        chk("sb_done", int'(bus.done), e.done);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int held;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    bus.hold  = 1'b0;
    set_cfg(0, 0, 0, 0);
    model_reset();
    #2 rst = 1'b0;
    #1;
    chk("rst_count", int'(bus.count), 0);
    chk("rst_state", int'(bus.state), IDLE);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_tc", int'(bus.tc_pulse), 0);
    tick_cycle();
    tick_cycle();
    rst = 1'b1;

    // up, one-shot
    set_cfg(1, 0, 3, 0);
    pulse_start();
    chk("up_load", int'(bus.state), LOAD);
    for (int i = 0; i < 4; i++) begin
      tick_cycle();
      chk("up_count", int'(bus.count), i);
    end
    tick_cycle();
    chk("up_tc", int'(bus.tc_pulse), 1);
    chk("up_done", int'(bus.done), 1);
    chk("up_hold3", int'(bus.count), 3);
    tick_cycle();
    chk("up_tc_once", int'(bus.tc_pulse), 0);

    // down with prescaler
    set_cfg(0, 0, 2, 2);
    pulse_start();
    tick_cycle();
    chk("dn_e1", int'(bus.count), 2);
    repeat (3) tick_cycle();
    chk("dn_e4", int'(bus.count), 1);
    repeat (3) tick_cycle();
    chk("dn_e7", int'(bus.count), 0);
    repeat (2) tick_cycle();
    chk("dn_e9_tc", int'(bus.tc_pulse), 0);
    tick_cycle();
    chk("dn_e10_tc", int'(bus.tc_pulse), 1);
    chk("dn_e10_st", int'(bus.state), DONE);

    // auto-reload
    set_cfg(1, 1, 1, 0);
    pulse_start();
    for (int k = 1; k <= 6; k++) begin
      tick_cycle();
      chk("ar_count", int'(bus.count), (k - 1) % 2);
      chk("ar_tc", int'(bus.tc_pulse), (k >= 3 && k % 2 == 1) ? 1 : 0);
    end
    bus.stop = 1'b1;
    tick_cycle();
    bus.stop = 1'b0;
    chk("ar_stop_st", int'(bus.state), IDLE);
    chk("ar_stop_cnt", int'(bus.count), 1);

    // hold freezes count and prescaler phase
    set_cfg(1, 0, 6, 1);
    pulse_start();
    repeat (5) tick_cycle();
    chk("hd_pre", int'(bus.count), 2);
    bus.hold = 1'b1;
    repeat (4) tick_cycle();
    chk("hd_state", int'(bus.state), HOLD);
    chk("hd_count", int'(bus.count), 2);
    bus.hold = 1'b0;
    tick_cycle();
    chk("hd_resume", int'(bus.state), RUN);
    tick_cycle();
    chk("hd_e11", int'(bus.count), 2);
    tick_cycle();
    chk("hd_e12", int'(bus.count), 3);
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    tick_cycle();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    chk("prio_stop", int'(bus.state), IDLE);

    // reset in the middle of RUN
    set_cfg(1, 0, 5, 0);
    pulse_start();
    repeat (4) tick_cycle();
    chk("mr_pre", int'(bus.count), 3);
    rst = 1'b0;
    sbq.delete();
    model_reset();
    #1;
    chk("mr_count", int'(bus.count), 0);
    chk("mr_state", int'(bus.state), IDLE);
    chk("mr_busy", int'(bus.busy), 0);
    chk("mr_tc", int'(bus.tc_pulse), 0);
    tick_cycle();
    rst = 1'b1;

    // shadowing of config
    set_cfg(1, 0, 4, 0);
    pulse_start();
    tick_cycle();
    set_cfg(0, 1, 1, 3);
    repeat (4) tick_cycle();
    chk("sh_e5", int'(bus.count), 4);
    tick_cycle();
    chk("sh_done", int'(bus.done), 1);
    chk("sh_tc", int'(bus.tc_pulse), 1);
    pulse_start();
    tick_cycle();
    chk("sh_new", int'(bus.count), 1);

    // randomized commands and config
    held = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 99) < 8) held = 1 - held;
      bus.hold  = 1'(held);
      bus.start = ($urandom_range(0, 99) < 4);
      bus.stop  = ($urandom_range(0, 99) < 2);
      bus.dir         = 1'($urandom_range(0, 1));
      bus.auto_reload = 1'($urandom_range(0, 1));
      bus.load_val    = ($urandom_range(0, 3) == 0) ?
                        8'($urandom_range(0, 255)) : 8'($urandom_range(0, 5));
      bus.prescale    = ($urandom_range(0, 3) == 0) ?
                        4'($urandom_range(0, 15)) : 4'($urandom_range(0, 2));
      if ($urandom_range(0, 499) == 0) begin
        rst = 1'b0;
        sbq.delete();
        model_reset();
        tick_cycle();
        rst = 1'b1;
      end else begin
        tick_cycle();
      end
    end
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    bus.hold  = 1'b0;
    @(negedge clk);
    #1;
    chk("sb_drain", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/counter_ctrl.md
Name: counter_ctrl

Overview:
Sequencing controller for a programmable modulo counter built from async-reset flops.
- Accepts start, stop and hold commands and owns a prescaler.
- Counts up from 0 to a loaded terminal value, or down from that value to 0.
- Flags terminal count and either finishes or auto-reloads.
- Sits between software-style control strobes and the counter datapath; exposes count and status.

Parameters:
WIDTH, 8, counter width in bits
PRE_WIDTH, 4, prescaler divide-field width; tick period = prescale+1 clk cycles

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset
start  input  1  level; starts or restarts a count sequence
stop  input  1  level; aborts to IDLE
hold  input  1  level; freezes counter and prescaler while in RUN
dir  input  1  1 = count up, 0 = count down; sampled at start
auto_reload  input  1  1 = restart on terminal count, 0 = go to DONE; sampled at start
load_val  input  WIDTH  terminal (up) or initial (down) value; sampled at start
prescale  input  PRE_WIDTH  tick divider; sampled at start
count  output  WIDTH  current count value
tc_pulse  output  1  one-cycle pulse; terminal tick was processed
busy  output  1  high in LOAD, RUN, HOLD
done  output  1  high in DONE
state  output  3  FSM state, for debug

Behaviour:
Reset is asynchronous and active-low. While rst=0:
- state=IDLE; count=0; tc_pulse=0; busy=0; done=0.
- All shadow registers (dir, auto_reload, load_val, prescale) = 0; prescaler = 0.
- Reset mid-sequence aborts immediately. No pending tc_pulse survives.

State encoding: IDLE=0, LOAD=1, RUN=2, HOLD=3, DONE=4. Codes 5–7 recover to IDLE on the next edge.

Command priority each cycle: stop > start > hold > tick.

Transitions:
- IDLE: start -> LOAD; otherwise stay, count holds.
- LOAD (exactly 1 cycle):
  - Shadows were captured on the edge that entered LOAD.
  - On exit: count <= (dir ? 0 : load_val); prescaler <= 0; next state RUN.
  - stop during LOAD -> IDLE with count unchanged.
- RUN:
  - Prescaler increments each cycle; tick when prescaler == prescale_shadow, then prescaler wraps to 0.
  - On a tick with count == terminal (up: load_val_shadow; down: 0):
    - tc_pulse = 1 next cycle.
    - If auto_reload_shadow: count <= start value, stay RUN.
    - Otherwise -> DONE, count holds at terminal.
  - On a tick otherwise: count <= count ± 1.
  - hold=1 -> HOLD; no count or prescaler change that cycle.
  - start -> LOAD (restart, new shadows).
  - stop -> IDLE.
- HOLD: count and prescaler frozen. hold=0 -> RUN (prescaler resumes from its frozen value). start -> LOAD. stop -> IDLE.
- DONE: done=1, count holds. start -> LOAD; stop -> IDLE.

Timing (start sampled at edge E0):
- E0: state LOAD.
- E1: RUN, count = start value.
- First tick edge is E1+prescale+1.
- Count changes every prescale+1 cycles.

Signal rules:
- tc_pulse is registered; never high for two consecutive cycles unless prescale=0 with auto_reload=1 and load_val=0.
- load_val=0 means the first tick is terminal.
- Input changes to dir, load_val, prescale or auto_reload outside the start-sampling edge have no effect.
- No overflow or underflow is possible: count stays within [0, load_val_shadow].
- All outputs are registered or decoded from the state register only; no combinational input-to-output paths.

Decomposition:
- Shared include counter_ctrl_defs.vh holds the state encoding localparams (S_IDLE..S_DONE) and the 3-bit state width constant. Future counter controllers and benches reuse it.
- One sub-module, counter_prescaler:
  - Ports: clk, rst, clr, en, div[PRE_WIDTH], tick.
  - Async active-low reset.
  - clr forces 0; en=0 freezes; tick is combinational (cnt==div && en).
- The count register and FSM stay in counter_ctrl.

Test Plan:
1. Reset mid-RUN: WIDTH=8, load_val=5, count=3, rst pulled low between edges -> count=0, state=0, busy=0, tc_pulse=0 immediately, before the next edge.
2. Up, one-shot: dir=1, load_val=3, prescale=0, auto_reload=0, start pulse at E0 -> count 0,1,2,3 at E1..E4; tc_pulse=1 after E5; state=DONE, done=1, count stays 3.
3. Down with prescaler: dir=0, load_val=2, prescale=2 -> count 2 at E1, 1 at E4, 0 at E7; tc_pulse after E10; DONE.
4. Auto-reload: dir=1, load_val=1, prescale=0, auto_reload=1 -> count 0,1,0,1,…; tc_pulse every 2nd cycle; state stays RUN until stop -> IDLE next edge, count held.
5. Hold and priority: in RUN at count=2, hold=1 for 4 cycles -> count and prescaler frozen, state=HOLD. hold=0 -> resumes at 3. Assert start and stop together -> IDLE, not LOAD.
6. Shadowing: start with load_val=4, change load_val to 1 and dir to 0 during RUN -> sequence still ends at 4 counting up; new values take effect only after a fresh start.
